// File: rtl/mac_vector_sequencer_if.sv
// rtl/mac_vector_sequencer_if.sv - operand, PE and result signal bundle for mac_vector_sequencer
// Optional perf counter signals exist only when MAC_SEQ_PERF_CNT_EN is defined.
interface mac_vector_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
);
  logic                  i_op_valid;
  logic                  o_op_ready;
  logic [DATA_WIDTH-1:0] i_op_a;
  logic [DATA_WIDTH-1:0] i_op_b;
  logic [DATA_WIDTH-1:0] o_pe_a;
  logic [DATA_WIDTH-1:0] o_pe_b;
  logic                  o_pe_enable;
  logic                  o_pe_clear;
  logic [ACC_WIDTH-1:0]  i_pe_result;
  logic                  i_pe_overflow;
  logic                  i_pe_done;
  logic                  o_res_valid;
  logic                  i_res_ready;
  logic [ACC_WIDTH-1:0]  o_res_data;
  logic                  o_res_overflow;
  logic                  o_res_timeout;
  logic                  o_busy;
`ifdef MAC_SEQ_PERF_CNT_EN
  logic [15:0]           o_vec_count;
  logic [15:0]           o_stall_count;

  modport master (
    input  i_op_valid, i_op_a, i_op_b, i_pe_result, i_pe_overflow, i_pe_done, i_res_ready,
    output o_op_ready, o_pe_a, o_pe_b, o_pe_enable, o_pe_clear,
           o_res_valid, o_res_data, o_res_overflow, o_res_timeout, o_busy,
           o_vec_count, o_stall_count
  );

  modport slave (
    output i_op_valid, i_op_a, i_op_b, i_pe_result, i_pe_overflow, i_pe_done, i_res_ready,
    input  o_op_ready, o_pe_a, o_pe_b, o_pe_enable, o_pe_clear,
           o_res_valid, o_res_data, o_res_overflow, o_res_timeout, o_busy,
           o_vec_count, o_stall_count
  );
`else
  modport master (
    input  i_op_valid, i_op_a, i_op_b, i_pe_result, i_pe_overflow, i_pe_done, i_res_ready,
    output o_op_ready, o_pe_a, o_pe_b, o_pe_enable, o_pe_clear,
           o_res_valid, o_res_data, o_res_overflow, o_res_timeout, o_busy
  );

  modport slave (
    output i_op_valid, i_op_a, i_op_b, i_pe_result, i_pe_overflow, i_pe_done, i_res_ready,
    input  o_op_ready, o_pe_a, o_pe_b, o_pe_enable, o_pe_clear,
           o_res_valid, o_res_data, o_res_overflow, o_res_timeout, o_busy
  );
`endif
endinterface

// File: rtl/mac_vector_sequencer.sv
// rtl/mac_vector_sequencer.sv - groups operand pairs into vectors and drives one PE MAC lane
// Optional macro MAC_SEQ_PERF_CNT_EN adds result and stall counters.
module mac_vector_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int VEC_LEN      = 9,
  parameter int DONE_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    i_reset,
  mac_vector_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_FEED      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(VEC_LEN - 1);
  localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  op_ready_q, op_ready_d;
  logic [DATA_WIDTH-1:0] pe_a_q, pe_a_d;
  logic [DATA_WIDTH-1:0] pe_b_q, pe_b_d;
  logic                  pe_en_q, pe_en_d;
  logic                  pe_clr_q, pe_clr_d;
  logic                  res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
  logic                  res_ovf_q, res_ovf_d;
  logic                  res_tmo_q, res_tmo_d;
  logic                  busy_q, busy_d;
  logic                  op_hs;
  logic                  res_hs;

  assign op_hs  = bus.i_op_valid & op_ready_q;
  assign res_hs = res_valid_q & bus.i_res_ready;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      tmo_q       <= '0;
      op_ready_q  <= 1'b0;
      pe_a_q      <= '0;
      pe_b_q      <= '0;
      pe_en_q     <= 1'b0;
      pe_clr_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_tmo_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      op_ready_q  <= op_ready_d;
      pe_a_q      <= pe_a_d;
      pe_b_q      <= pe_b_d;
      pe_en_q     <= pe_en_d;
      pe_clr_q    <= pe_clr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_tmo_q   <= res_tmo_d;
      busy_q      <= busy_d;
    end
  end

  // Outputs are registered, so each *_d reflects what the next state must present.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    tmo_d       = tmo_q;
    pe_a_d      = pe_a_q;
    pe_b_d      = pe_b_q;
    pe_en_d     = 1'b0;
    pe_clr_d    = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_tmo_d   = res_tmo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_op_valid) begin
          state_d  = S_CLEAR;
          pe_clr_d = 1'b1;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        count_d = '0;
      end
      S_FEED: begin
        if (op_hs) begin
          pe_a_d  = bus.i_op_a;
          pe_b_d  = bus.i_op_b;
          pe_en_d = 1'b1;
          count_d = count_q + 8'd1;
          if (count_q == LAST_IDX) begin
            state_d = S_WAIT_DONE;
            tmo_d   = '0;
          end
        end
      end
      S_WAIT_DONE: begin
        tmo_d = tmo_q + 8'd1;
        // First WAIT_DONE cycle is still the final enable cycle, so done is not trusted yet.
        if ((tmo_q != 8'd0) && bus.i_pe_done) begin
          state_d     = S_HOLD;
          res_valid_d = 1'b1;
          res_data_d  = bus.i_pe_result;
          res_ovf_d   = bus.i_pe_overflow;
          res_tmo_d   = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = S_HOLD;
          res_valid_d = 1'b1;
          res_data_d  = bus.i_pe_result;
          res_ovf_d   = bus.i_pe_overflow;
          res_tmo_d   = 1'b1;
        end
      end
      S_HOLD: begin
        if (res_hs) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    op_ready_d = (state_d == S_FEED);
    busy_d     = (state_d != S_IDLE);
  end

  assign bus.o_op_ready     = op_ready_q;
  assign bus.o_pe_a         = pe_a_q;
  assign bus.o_pe_b         = pe_b_q;
  assign bus.o_pe_enable    = pe_en_q;
  assign bus.o_pe_clear     = pe_clr_q;
  assign bus.o_res_valid    = res_valid_q;
  assign bus.o_res_data     = res_data_q;
  assign bus.o_res_overflow = res_ovf_q;
  assign bus.o_res_timeout  = res_tmo_q;
  assign bus.o_busy         = busy_q;

`ifdef MAC_SEQ_PERF_CNT_EN
  logic [15:0] vec_cnt_q, vec_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    vec_cnt_d   = vec_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (res_hs) begin
      vec_cnt_d = vec_cnt_q + 16'd1;
    end
    if ((state_q == S_FEED) && op_ready_q && !bus.i_op_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      vec_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      vec_cnt_q   <= vec_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_vec_count   = vec_cnt_q;
  assign bus.o_stall_count = stall_cnt_q;
`endif

endmodule
